// File: rtl/adc_spi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_master_if
// Purpose  : Command / response bus between a host (test harness, sequencer
//            or CPU bridge) and adc_spi_master.
// Signals  : cmd_valid/cmd_ready  command handshake
//            cmd_rw/addr/wdata    command payload (rw=1 read)
//            rsp_valid/rsp_rdata  one-cycle response strobe with read data
//            busy                 frame in progress
// Modports : master - host side, issues commands
//            slave  - adc_spi_master side, executes commands
// Revision : 1.0 - initial release
// ============================================================================
interface adc_spi_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [2:0]  cmd_addr;
  logic [11:0] cmd_wdata;
  logic        rsp_valid;
  logic [11:0] rsp_rdata;
  logic        busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/adc_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_master
// Purpose  : SPI mode-0 master for the spi_adc register interface. Each
//            accepted command becomes one 16-bit frame
//            {rw, addr[2:0], wdata[11:0] or 0}, MSB first. The 12 bits seen
//            on miso during bit slots 11:0 are returned on rsp_rdata.
// Ports    : sys_clk, reset_ (async, active-low)
//            bus      - adc_spi_master_if.slave (cmd_*, rsp_*, busy)
//            cs, sck, mosi, miso - SPI pins (cs active-low, sck idles low)
//            irq      - ADC interrupt (only used with the auto-read option)
//            sample_valid, sample_data, overrun - auto-read results
// Options  : `define ADC_IRQ_AUTOREAD_EN to enable automatic DATA reads on
//            rising irq edges. Without it the auto-read outputs are tied 0.
// Params   : SCK_DIV - sys_clk cycles per SCK half-period (4..255)
//            CS_GAP  - SCK half-periods cs stays high between frames
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_master #(
  parameter int SCK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic               sys_clk,
  input  logic               reset_,
  adc_spi_master_if.slave    bus,
  output logic               cs,
  output logic               sck,
  output logic               mosi,
  input  logic               miso,
  input  logic               irq,
  output logic               sample_valid,
  output logic [11:0]        sample_data,
  output logic               overrun
);

  localparam logic [15:0] C_HALF_LAST  = 16'(SCK_DIV - 1);
  localparam logic [15:0] C_GAP_LAST   = 16'(CS_GAP * SCK_DIV - 1);
  localparam logic [15:0] C_AUTO_FRAME = 16'h9000;  // read of DATA (addr 1)

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;    // cycles left in the current half-period / gap
  logic [4:0]  r_half;   // SHIFT half-period index; even = sck high
  logic [15:0] r_tx;
  logic [11:0] r_rx;     // keeps only the last 12 samples = slots 11:0

  logic        w_accept;
  logic        w_start;
  logic [15:0] w_cmd_frame;
  logic [15:0] w_start_frame;

  assign w_accept    = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_cmd_frame = {bus.cmd_rw, bus.cmd_addr,
                        bus.cmd_rw ? 12'h000 : bus.cmd_wdata};

`ifdef ADC_IRQ_AUTOREAD_EN
  logic r_irq_s1;
  logic r_irq_s2;
  logic r_irq_d;
  logic r_pending;
  logic r_auto;      // current frame was started by irq, not by the host
  logic w_irq_rise;
  logic w_auto_start;

  assign w_irq_rise   = r_irq_s2 && !r_irq_d;
  // Host commands always win; the pending request waits for a free IDLE cycle.
  assign w_auto_start = (r_state == ST_IDLE) && !bus.cmd_valid && r_pending;

  always_ff @(posedge sys_clk or negedge reset_) begin
    if (!reset_) begin
      r_irq_s1  <= 1'b0;
      r_irq_s2  <= 1'b0;
      r_irq_d   <= 1'b0;
      r_pending <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_irq_s1 <= irq;
      r_irq_s2 <= r_irq_s1;
      r_irq_d  <= r_irq_s2;
      overrun  <= 1'b0;
      // A new edge re-arms pending even if the start clears it this cycle.
      if (w_irq_rise) begin
        r_pending <= 1'b1;
        if (r_pending || r_auto) begin
          overrun <= 1'b1;
        end
      end else if (w_auto_start) begin
        r_pending <= 1'b0;
      end
    end
  end
`else
  logic w_unused_irq;
  assign w_unused_irq = irq;
  assign overrun      = 1'b0;
  assign sample_valid = 1'b0;
  assign sample_data  = 12'h000;
`endif

  always_comb begin
    w_start       = w_accept;
    w_start_frame = w_cmd_frame;
`ifdef ADC_IRQ_AUTOREAD_EN
    if (w_auto_start) begin
      w_start       = 1'b1;
      w_start_frame = C_AUTO_FRAME;
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge reset_) begin
    if (!reset_) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 16'd0;
      r_half         <= 5'd0;
      r_tx           <= 16'd0;
      r_rx           <= 12'd0;
      cs             <= 1'b1;
      sck            <= 1'b0;
      mosi           <= 1'b0;
      bus.busy       <= 1'b0;
      bus.cmd_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= 12'd0;
`ifdef ADC_IRQ_AUTOREAD_EN
      r_auto         <= 1'b0;
      sample_valid   <= 1'b0;
      sample_data    <= 12'd0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
`ifdef ADC_IRQ_AUTOREAD_EN
      sample_valid  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_tx          <= w_start_frame;
            mosi          <= w_start_frame[15];
            cs            <= 1'b0;
            bus.busy      <= 1'b1;
            bus.cmd_ready <= 1'b0;
            r_cnt         <= C_HALF_LAST;
            r_state       <= ST_SETUP;
`ifdef ADC_IRQ_AUTOREAD_EN
            r_auto        <= !w_accept;
`endif
          end
        end

        ST_SETUP: begin
          if (r_cnt == 16'd0) begin
            sck     <= 1'b1;
            r_half  <= 5'd0;
            r_cnt   <= C_HALF_LAST;
            r_state <= ST_SHIFT;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        ST_SHIFT: begin
          if (r_cnt == 16'd0) begin
            r_cnt <= C_HALF_LAST;
            // Sample at the tail of the high phase so the slave's sck
            // synchroniser has long since updated miso.
            if (!r_half[0]) begin
              r_rx <= {r_rx[10:0], miso};
            end
            if (r_half == 5'd31) begin
              sck     <= 1'b0;
              r_state <= ST_HOLD;
            end else begin
              r_half <= r_half + 5'd1;
              sck    <= ~sck;
              if (!r_half[0]) begin
                r_tx <= {r_tx[14:0], 1'b0};
                mosi <= r_tx[14];
              end
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        ST_HOLD: begin
          if (r_cnt == 16'd0) begin
            cs <= 1'b1;
`ifdef ADC_IRQ_AUTOREAD_EN
            if (r_auto) begin
              sample_valid <= 1'b1;
              sample_data  <= r_rx;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= r_rx;
            end
            r_auto <= 1'b0;
`else
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= r_rx;
`endif
            if (CS_GAP == 0) begin
              bus.busy      <= 1'b0;
              bus.cmd_ready <= 1'b1;
              r_state       <= ST_IDLE;
            end else begin
              r_cnt   <= C_GAP_LAST;
              r_state <= ST_GAP;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        ST_GAP: begin
          if (r_cnt == 16'd0) begin
            bus.busy      <= 1'b0;
            bus.cmd_ready <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_master
// Purpose  : Directed bench for adc_spi_master (SCK_DIV=4, CS_GAP=2) with a
//            behavioural mode-0 SPI slave. Auto-read scenarios are compiled
//            when ADC_IRQ_AUTOREAD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_master;

  logic        sys_clk = 1'b0;
  logic        reset_  = 1'b1;
  logic        cs;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        irq = 1'b0;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic        overrun;

  adc_spi_master_if u_bus ();

  adc_spi_master #(.SCK_DIV(4), .CS_GAP(2)) dut (
    .sys_clk      (sys_clk),
    .reset_       (reset_),
    .bus          (u_bus.slave),
    .cs           (cs),
    .sck          (sck),
    .mosi         (mosi),
    .miso         (miso),
    .irq          (irq),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .overrun      (overrun)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int tests  = 0;
  int failed = 0;

  // Behavioural slave: shifts slv_resp out MSB first, updating after each
  // rising sck edge so the value is stable through the high phase.
  logic [15:0] slv_resp = 16'h0000;
  int          slv_rises = 0;

  always @(posedge sck or posedge cs) begin
    if (cs) slv_rises <= 0;
    else    slv_rises <= slv_rises + 1;
  end

  always_comb begin
    miso = 1'b0;
    if (slv_rises >= 1 && slv_rises <= 16) miso = slv_resp[16 - slv_rises];
  end

  // Frame monitor, sampled on the falling sys_clk edge.
  int          frame_cnt = 0;
  int          rsp_cnt   = 0;
  int          smp_cnt   = 0;
  int          ovr_cnt   = 0;
  logic [11:0] rsp_data_seen = 12'h0;
  logic [11:0] smp_data_seen = 12'h0;
  logic        prev_cs  = 1'b1;
  logic        prev_sck = 1'b0;
  int          cs_low_cnt = 0;
  int          cs_high_run = 0;
  int          sck_rises = 0;
  logic [15:0] mosi_word = 16'h0;
  bit          busy_drop = 1'b0;
  logic [15:0] log_word [16];
  int          log_len  [16];
  int          log_rises[16];
  int          log_gap  [16];
  bit          log_rsp_at_rise [16];
  bit          log_busy_drop   [16];

  always @(negedge sys_clk) begin
    if (!cs && prev_cs) begin
      log_gap[frame_cnt % 16] = cs_high_run;
      cs_low_cnt = 0;
      sck_rises  = 0;
      mosi_word  = 16'h0;
      busy_drop  = 1'b0;
    end
    if (!cs) begin
      cs_high_run = 0;
      cs_low_cnt++;
      if (sck && !prev_sck) begin
        sck_rises++;
        mosi_word = {mosi_word[14:0], mosi};
      end
      if (!u_bus.busy) busy_drop = 1'b1;
    end else begin
      cs_high_run++;
    end
    if (cs && !prev_cs) begin
      log_word[frame_cnt % 16]        = mosi_word;
      log_len[frame_cnt % 16]         = cs_low_cnt;
      log_rises[frame_cnt % 16]       = sck_rises;
      log_rsp_at_rise[frame_cnt % 16] = u_bus.rsp_valid;
      log_busy_drop[frame_cnt % 16]   = busy_drop;
      frame_cnt++;
    end
    if (u_bus.rsp_valid) begin
      rsp_cnt++;
      rsp_data_seen = u_bus.rsp_rdata;
    end
    if (sample_valid) begin
      smp_cnt++;
      smp_data_seen = sample_data;
    end
    if (overrun) ovr_cnt++;
    prev_cs  = cs;
    prev_sck = sck;
  end

  task automatic issue(input logic rw, input logic [2:0] addr, input logic [11:0] wdata);
    @(negedge sys_clk);
    u_bus.cmd_valid = 1'b1;
    u_bus.cmd_rw    = rw;
    u_bus.cmd_addr  = addr;
    u_bus.cmd_wdata = wdata;
    @(posedge sys_clk);
    #1;
    u_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      n++;
      if (u_bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_frames(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      #1;
      if (frame_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    u_bus.cmd_valid = 1'b0;
    u_bus.cmd_rw    = 1'b0;
    u_bus.cmd_addr  = 3'd0;
    u_bus.cmd_wdata = 12'h0;
    #2 reset_ = 1'b0;
    repeat (3) @(negedge sys_clk);
    tests++; if (cs !== 1'b1) begin failed++; $display("FAIL reset_cs got %b want 1", cs); end
    tests++; if (sck !== 1'b0) begin failed++; $display("FAIL reset_sck got %b want 0", sck); end
    tests++; if (mosi !== 1'b0) begin failed++; $display("FAIL reset_mosi got %b want 0", mosi); end
    tests++; if (u_bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", u_bus.busy); end
    tests++; if (u_bus.cmd_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got %b want 1", u_bus.cmd_ready); end
    tests++; if (u_bus.rsp_valid !== 1'b0) begin failed++; $display("FAIL reset_rsp_valid got %b want 0", u_bus.rsp_valid); end
    tests++; if (u_bus.rsp_rdata !== 12'h000) begin failed++; $display("FAIL reset_rsp_rdata got %h want 000", u_bus.rsp_rdata); end
    tests++; if (sample_valid !== 1'b0) begin failed++; $display("FAIL reset_sample_valid got %b want 0", sample_valid); end
    tests++; if (sample_data !== 12'h000) begin failed++; $display("FAIL reset_sample_data got %h want 000", sample_data); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL reset_overrun got %b want 0", overrun); end
    reset_ = 1'b1;
    repeat (3) @(negedge sys_clk);
    tests++; if (cs !== 1'b1 || u_bus.cmd_ready !== 1'b1) begin failed++; $display("FAIL post_reset_idle got cs=%b ready=%b want 1 1", cs, u_bus.cmd_ready); end
  endtask

  task automatic test_write;
    int n; bit ok; int f0; int r0; int k;
    slv_resp = 16'h0777;
    f0 = frame_cnt; r0 = rsp_cnt;
    issue(1'b0, 3'd0, 12'h013);
    wait_ready(n, ok);
    k = f0 % 16;
    tests++; if (!ok) begin failed++; $display("FAIL write_ready_timeout got timeout want ready"); end
    tests++; if (n !== 145) begin failed++; $display("FAIL write_ready_latency got %0d want 145", n); end
    tests++; if (frame_cnt !== f0 + 1) begin failed++; $display("FAIL write_frames got %0d want %0d", frame_cnt - f0, 1); end
    tests++; if (log_word[k] !== 16'h0013) begin failed++; $display("FAIL write_mosi got %h want 0013", log_word[k]); end
    tests++; if (log_len[k] !== 136) begin failed++; $display("FAIL write_cs_low got %0d want 136", log_len[k]); end
    tests++; if (log_rises[k] !== 16) begin failed++; $display("FAIL write_sck_rises got %0d want 16", log_rises[k]); end
    tests++; if (rsp_cnt !== r0 + 1) begin failed++; $display("FAIL write_rsp_pulses got %0d want 1", rsp_cnt - r0); end
    tests++; if (log_rsp_at_rise[k] !== 1'b1) begin failed++; $display("FAIL write_rsp_at_cs_rise got %b want 1", log_rsp_at_rise[k]); end
    tests++; if (rsp_data_seen !== 12'h777) begin failed++; $display("FAIL write_rsp_rdata got %h want 777", rsp_data_seen); end
    repeat (5) @(negedge sys_clk);
    tests++; if (u_bus.rsp_rdata !== 12'h777) begin failed++; $display("FAIL write_rdata_hold got %h want 777", u_bus.rsp_rdata); end
  endtask

  task automatic test_read;
    int n; bit ok; int f0; int r0; int k;
    slv_resp = 16'h0ABC;
    f0 = frame_cnt; r0 = rsp_cnt;
    issue(1'b1, 3'd1, 12'hFFF);
    wait_ready(n, ok);
    k = f0 % 16;
    tests++; if (!ok) begin failed++; $display("FAIL read_ready_timeout got timeout want ready"); end
    tests++; if (log_word[k] !== 16'h9000) begin failed++; $display("FAIL read_mosi got %h want 9000", log_word[k]); end
    tests++; if (rsp_cnt !== r0 + 1) begin failed++; $display("FAIL read_rsp_pulses got %0d want 1", rsp_cnt - r0); end
    tests++; if (rsp_data_seen !== 12'hABC) begin failed++; $display("FAIL read_rsp_rdata got %h want abc", rsp_data_seen); end
    tests++; if (log_busy_drop[k] !== 1'b0) begin failed++; $display("FAIL read_busy_in_frame got drop=%b want 0", log_busy_drop[k]); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_w [3];
    logic        c_rw  [3];
    logic [2:0]  c_ad  [3];
    logic [11:0] c_wd  [3];
    int n_acc; bit took; int f0; int n; bit ok; int guard;
    c_rw[0] = 1'b0; c_ad[0] = 3'd0; c_wd[0] = 12'h0A5; exp_w[0] = 16'h00A5;
    c_rw[1] = 1'b1; c_ad[1] = 3'd2; c_wd[1] = 12'h555; exp_w[1] = 16'hA000;
    c_rw[2] = 1'b0; c_ad[2] = 3'd1; c_wd[2] = 12'h123; exp_w[2] = 16'h1123;
    slv_resp = 16'h0246;
    f0 = frame_cnt; n_acc = 0; guard = 0;
    @(negedge sys_clk);
    u_bus.cmd_valid = 1'b1;
    u_bus.cmd_rw = c_rw[0]; u_bus.cmd_addr = c_ad[0]; u_bus.cmd_wdata = c_wd[0];
    took = u_bus.cmd_ready;
    while (n_acc < 3 && guard < 2000) begin
      @(negedge sys_clk);
      guard++;
      if (took) begin
        n_acc++;
        if (n_acc < 3) begin
          u_bus.cmd_rw = c_rw[n_acc]; u_bus.cmd_addr = c_ad[n_acc]; u_bus.cmd_wdata = c_wd[n_acc];
        end else begin
          u_bus.cmd_valid = 1'b0;
        end
      end
      took = u_bus.cmd_ready;
    end
    u_bus.cmd_valid = 1'b0;
    wait_ready(n, ok);
    repeat (20) @(negedge sys_clk);
    #1;
    tests++; if (!ok || n_acc != 3) begin failed++; $display("FAIL b2b_timeout got accepts=%0d want 3", n_acc); end
    tests++; if (frame_cnt !== f0 + 3) begin failed++; $display("FAIL b2b_frames got %0d want 3", frame_cnt - f0); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (log_word[(f0 + i) % 16] !== exp_w[i]) begin failed++; $display("FAIL b2b_mosi%0d got %h want %h", i, log_word[(f0 + i) % 16], exp_w[i]); end
      tests++; if (log_len[(f0 + i) % 16] !== 136) begin failed++; $display("FAIL b2b_cs_low%0d got %0d want 136", i, log_len[(f0 + i) % 16]); end
    end
    for (int i = 1; i < 3; i++) begin
      tests++; if (log_gap[(f0 + i) % 16] < 8) begin failed++; $display("FAIL b2b_gap%0d got %0d want >=8", i, log_gap[(f0 + i) % 16]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n; bit ok; int r0; int k; int guard;
    slv_resp = 16'h0FFF;
    r0 = rsp_cnt;
    issue(1'b1, 3'd1, 12'h000);
    guard = 0;
    while (slv_rises < 9 && guard < 500) begin
      @(negedge sys_clk);
      guard++;
    end
    tests++; if (slv_rises < 9) begin failed++; $display("FAIL midrst_reach_bit7 got rises=%0d want 9", slv_rises); end
    #2 reset_ = 1'b0;
    #1;
    tests++; if (cs !== 1'b1 || sck !== 1'b0) begin failed++; $display("FAIL midrst_pins got cs=%b sck=%b want 1 0", cs, sck); end
    tests++; if (u_bus.busy !== 1'b0 || u_bus.cmd_ready !== 1'b1 || mosi !== 1'b0) begin failed++; $display("FAIL midrst_state got busy=%b ready=%b mosi=%b want 0 1 0", u_bus.busy, u_bus.cmd_ready, mosi); end
    @(negedge sys_clk);
    reset_ = 1'b1;
    repeat (10) @(negedge sys_clk);
    #1;
    tests++; if (rsp_cnt !== r0) begin failed++; $display("FAIL midrst_no_rsp got %0d pulses want 0", rsp_cnt - r0); end
    slv_resp = 16'h0000;
    issue(1'b0, 3'd2, 12'h5A5);
    wait_ready(n, ok);
    k = (frame_cnt - 1) % 16;
    tests++; if (!ok || n !== 145) begin failed++; $display("FAIL midrst_next_latency got %0d want 145", n); end
    tests++; if (log_word[k] !== 16'h25A5) begin failed++; $display("FAIL midrst_next_mosi got %h want 25a5", log_word[k]); end
    tests++; if (log_len[k] !== 136 || log_rises[k] !== 16) begin failed++; $display("FAIL midrst_next_shape got len=%0d rises=%0d want 136 16", log_len[k], log_rises[k]); end
    tests++; if (rsp_cnt !== r0 + 1) begin failed++; $display("FAIL midrst_next_rsp got %0d want 1", rsp_cnt - r0); end
  endtask

`ifdef ADC_IRQ_AUTOREAD_EN
  task automatic test_autoread;
    int n; bit ok; int f0; int r0; int s0; int o0;
    slv_resp = 16'h05A5;
    f0 = frame_cnt; r0 = rsp_cnt; s0 = smp_cnt; o0 = ovr_cnt;
    @(negedge sys_clk);
    irq = 1'b1;
    wait_frames(f0 + 1, ok);
    irq = 1'b0;
    wait_ready(n, ok);
    repeat (10) @(negedge sys_clk);
    #1;
    tests++; if (frame_cnt !== f0 + 1) begin failed++; $display("FAIL auto_frames got %0d want 1", frame_cnt - f0); end
    tests++; if (log_word[f0 % 16] !== 16'h9000) begin failed++; $display("FAIL auto_mosi got %h want 9000", log_word[f0 % 16]); end
    tests++; if (smp_cnt !== s0 + 1) begin failed++; $display("FAIL auto_sample_pulses got %0d want 1", smp_cnt - s0); end
    tests++; if (smp_data_seen !== 12'h5A5) begin failed++; $display("FAIL auto_sample_data got %h want 5a5", smp_data_seen); end
    tests++; if (rsp_cnt !== r0) begin failed++; $display("FAIL auto_no_rsp got %0d want 0", rsp_cnt - r0); end
    tests++; if (ovr_cnt !== o0) begin failed++; $display("FAIL auto_no_overrun got %0d want 0", ovr_cnt - o0); end
  endtask

  task automatic test_autoread_collision;
    int n; bit ok; int f0; int r0; int s0; int o0; int guard;
    slv_resp = 16'h0333;
    f0 = frame_cnt; r0 = rsp_cnt; s0 = smp_cnt; o0 = ovr_cnt;
    @(negedge sys_clk);
    irq = 1'b1;
    u_bus.cmd_valid = 1'b1; u_bus.cmd_rw = 1'b0; u_bus.cmd_addr = 3'd0; u_bus.cmd_wdata = 12'h001;
    @(posedge sys_clk);
    #1;
    u_bus.cmd_valid = 1'b0;
    wait_frames(f0 + 1, ok);
    guard = 0;
    while (cs !== 1'b0 && guard < 200) begin
      @(negedge sys_clk);
      guard++;
    end
    irq = 1'b0;
    repeat (8) @(negedge sys_clk);
    irq = 1'b1;
    wait_frames(f0 + 2, ok);
    irq = 1'b0;
    wait_frames(f0 + 3, ok);
    wait_ready(n, ok);
    repeat (10) @(negedge sys_clk);
    #1;
    tests++; if (frame_cnt !== f0 + 3) begin failed++; $display("FAIL coll_frames got %0d want 3", frame_cnt - f0); end
    tests++; if (log_word[f0 % 16] !== 16'h0001) begin failed++; $display("FAIL coll_write_first got %h want 0001", log_word[f0 % 16]); end
    tests++; if (log_word[(f0 + 1) % 16] !== 16'h9000) begin failed++; $display("FAIL coll_auto_second got %h want 9000", log_word[(f0 + 1) % 16]); end
    tests++; if (ovr_cnt !== o0 + 1) begin failed++; $display("FAIL coll_overrun got %0d cycles want 1", ovr_cnt - o0); end
    tests++; if (rsp_cnt !== r0 + 1) begin failed++; $display("FAIL coll_rsp got %0d want 1", rsp_cnt - r0); end
    tests++; if (smp_cnt !== s0 + 2) begin failed++; $display("FAIL coll_samples got %0d want 2", smp_cnt - s0); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef ADC_IRQ_AUTOREAD_EN
    test_autoread();
    test_autoread_collision();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
